// File: rtl/instr_fetch.sv
// instr_fetch: small in-order fetch/decode front end.
// Fetches 8-bit instruction words from a combinational ROM and splits each word into opcode/register/immediate
// fields. It then offers the decoded instruction to the execute unit over a valid/ready handshake.
// Optional feature macro: FETCH_JUMP_EN.
//   When it is defined, opcode 10 is a jump: PC <= IR[3:0], and the jump is never issued.
//   When it is undefined (the default build), opcode 10 is a NOP that is never issued.
module instr_fetch #(
   parameter logic [3:0] START_ADDR = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       issue_valid,
   input  logic       issue_ready,
   output logic [1:0] issue_op,
   output logic [1:0] issue_rd,
   output logic [1:0] issue_rs,
   output logic [3:0] issue_imm,
   output logic       halted,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      ISSUE = 2'b10,
      HALT  = 2'b11
   } FetchState;

   typedef enum logic [1:0] {
      OP_LDI  = 2'b00,
      OP_HALT = 2'b01,
      OP_JMP  = 2'b10,
      OP_ADD  = 2'b11
   } Opcode;

   FetchState state;
   FetchState nextState;
   logic [3:0] pc;
   logic [3:0] nextPc;
   logic [7:0] ir;
   logic       loadIr;
   Opcode      fetchOp;

   // The opcode decision in FETCH has to be made on the word arriving from the ROM this cycle,
   // not on IR, because IR only captures that word at the closing edge of the FETCH cycle.
   assign fetchOp = Opcode'(rom_data[7:6]);

   // The program counter drives the ROM directly, so the address is stable for the whole cycle.
   // The issue fields always show IR. Outside ISSUE they therefore keep the last fetched word,
   // and they read zero after reset.
   assign rom_addr  = pc;
   assign issue_op  = ir[7:6];
   assign issue_rd  = ir[5:4];
   assign issue_rs  = ir[3:2];
   assign issue_imm = ir[3:0];

   // State register. Reset is asynchronous, so a pending ISSUE is dropped immediately and not at the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Program counter and instruction register.
   // PC follows the next-PC decision every cycle.
   // IR only loads while a word is actually being fetched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
         ir <= '0;
      end else begin
         pc <= nextPc;
         if (loadIr) begin
            ir <= rom_data;
         end
      end
   end

   // Next-state and next-PC decisions.
   // start is honoured only from IDLE or HALT. In FETCH the incoming opcode chooses the next state:
   //   - HALT parks the front end, with PC already pointing past the halt word.
   //   - LDI and ADD go on to be issued.
   //   - Opcode 10 goes straight back to FETCH without being issued, either as a jump or as a NOP depending on the build.
   // ISSUE waits for the execute unit to take the instruction before fetching again.
   always_comb begin
      nextState = state;
      nextPc    = pc;
      loadIr    = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               nextState = FETCH;
               nextPc    = START_ADDR;
            end
         end
         FETCH: begin
            loadIr = 1'b1;
            nextPc = pc + 4'd1;
            case (fetchOp)
               OP_HALT: begin
                  nextState = HALT;
               end
               OP_JMP: begin
`ifdef FETCH_JUMP_EN
                  nextPc = rom_data[3:0];
`endif
                  nextState = FETCH;
               end
               default: begin
                  nextState = ISSUE;
               end
            endcase
         end
         ISSUE: begin
            if (issue_ready) begin
               nextState = FETCH;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Status outputs decoded purely from the current state.
   // Neither start nor issue_ready can reach them combinationally.
   always_comb begin
      issue_valid = 1'b0;
      halted      = 1'b0;
      busy        = 1'b0;
      case (state)
         FETCH: begin
            busy = 1'b1;
         end
         ISSUE: begin
            issue_valid = 1'b1;
            busy        = 1'b1;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized self-checking bench for instr_fetch.
// The ROM is a bench-side array that answers rom_addr combinationally.
// The random rounds compare the DUT against a program-level model. That model walks the ROM contents and lists
// the words that should be issued, and it records where the program halts.
module tb_instr_fetch;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic       issue_valid;
   logic       issue_ready;
   logic [1:0] issue_op;
   logic [1:0] issue_rd;
   logic [1:0] issue_rs;
   logic [3:0] issue_imm;
   logic       halted;
   logic       busy;

   logic [7:0] rom [16];
   logic [7:0] demoProg [8];
   logic [7:0] expQ [$];
   logic       expHalt;
   logic [3:0] haltPc;

   int vectors = 0;
   int miscompares = 0;

   instr_fetch #(.START_ADDR(4'd0)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_rd    (issue_rd),
      .issue_rs    (issue_rs),
      .issue_imm   (issue_imm),
      .halted      (halted),
      .busy        (busy)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The instruction memory answers in the same cycle as the address.
   assign rom_data = rom[rom_addr];

   // Compare one observed value with its expected value, and count both the comparison and any miscompare.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Check that the DUT is currently issuing word w, with every field decoded from it.
   task automatic checkIssue(input string tag, input logic [7:0] w);
      checkOutput({tag, "_valid"}, 16'(issue_valid), 16'd1);
      checkOutput({tag, "_op"},    16'(issue_op),    16'(w[7:6]));
      checkOutput({tag, "_rd"},    16'(issue_rd),    16'(w[5:4]));
      checkOutput({tag, "_rs"},    16'(issue_rs),    16'(w[3:2]));
      checkOutput({tag, "_imm"},   16'(issue_imm),   16'(w[3:0]));
   endtask

   // Drive start (for one cycle only) and issue_ready, then move to 1 unit after the next rising edge.
   task automatic applyStimulus(input logic s, input logic r);
      start       = s;
      issue_ready = r;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Assert reset across one rising edge, then release it away from the edge.
   task automatic doReset();
      start       = 1'b0;
      issue_ready = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Program-level reference model.
   // It starts at address 0 and walks the program, listing the words that must be issued in order.
   // It stops at the first HALT word, after 10 issued words, or after 64 fetches, whichever comes first.
   task automatic buildExpected();
      int         pcm;
      int         fetches;
      logic [7:0] w;
      expQ.delete();
      expHalt = 1'b0;
      haltPc  = 4'd0;
      pcm     = 0;
      fetches = 0;
      while (fetches < 64 && expQ.size() < 10 && !expHalt) begin
         w       = rom[pcm];
         fetches = fetches + 1;
         pcm     = (pcm + 1) % 16;
         case (w[7:6])
            2'b01: begin
               expHalt = 1'b1;
               haltPc  = 4'(pcm);
            end
            2'b10: begin
`ifdef FETCH_JUMP_EN
               pcm = int'(w[3:0]);
`endif
            end
            default: begin
               expQ.push_back(w);
            end
         endcase
      end
   endtask

   // Bound the whole run so that a stuck DUT can never hang the simulation.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized program rounds.
   initial begin
      logic [7:0] w;
      logic       nextReady;
      logic [3:0] jumpTarget;
      int         budget;

      demoProg = '{8'h01, 8'h11, 8'h21, 8'h31, 8'hC4, 8'hC8, 8'hCC, 8'h40};
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      for (int i = 0; i < 8; i++) rom[i] = demoProg[i];

      start       = 1'b0;
      issue_ready = 1'b0;
      rst         = 1'b0;
      #1;
      rst = 1'b1;
      #2;
      $display("[TB] reset state");
      checkOutput("rst_valid",  16'(issue_valid), 16'd0);
      checkOutput("rst_addr",   16'(rom_addr),    16'd0);
      checkOutput("rst_halted", 16'(halted),      16'd0);
      checkOutput("rst_busy",   16'(busy),        16'd0);
      checkOutput("rst_op",     16'(issue_op),    16'd0);
      checkOutput("rst_rd",     16'(issue_rd),    16'd0);
      checkOutput("rst_rs",     16'(issue_rs),    16'd0);
      checkOutput("rst_imm",    16'(issue_imm),   16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_busy", 16'(busy),     16'd0);
      checkOutput("idle_addr", 16'(rom_addr), 16'd0);

      $display("[TB] demo program, execute unit always ready");
      applyStimulus(1'b1, 1'b1);
      checkOutput("demo_fetch0_busy",  16'(busy),        16'd1);
      checkOutput("demo_fetch0_valid", 16'(issue_valid), 16'd0);
      checkOutput("demo_fetch0_addr",  16'(rom_addr),    16'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkIssue("demo_issue", demoProg[i]);
         checkOutput("demo_issue_addr", 16'(rom_addr), 16'(i + 1));
         applyStimulus(1'b0, 1'b1);
         checkOutput("demo_fetch_valid", 16'(issue_valid), 16'd0);
         checkOutput("demo_fetch_addr",  16'(rom_addr),    16'(i + 1));
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("demo_halted",     16'(halted),      16'd1);
      checkOutput("demo_halt_addr",  16'(rom_addr),    16'd8);
      checkOutput("demo_halt_valid", 16'(issue_valid), 16'd0);
      checkOutput("demo_halt_busy",  16'(busy),        16'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("demo_halt_hold",  16'(halted),   16'd1);
      checkOutput("demo_halt_addr2", 16'(rom_addr), 16'd8);
      checkOutput("demo_hold_op",    16'(issue_op), 16'd1);

      $display("[TB] restart from HALT, execute unit stalls first issue");
      applyStimulus(1'b1, 1'b0);
      checkOutput("restart_halted", 16'(halted),   16'd0);
      checkOutput("restart_busy",   16'(busy),     16'd1);
      checkOutput("restart_addr",   16'(rom_addr), 16'd0);
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checkIssue("stall_issue", demoProg[0]);
         checkOutput("stall_addr", 16'(rom_addr), 16'd1);
         applyStimulus(k == 2, 1'b0);
      end
      checkIssue("stall_last", demoProg[0]);
      applyStimulus(1'b0, 1'b1);
      checkOutput("stall_accept_valid", 16'(issue_valid), 16'd0);
      checkOutput("stall_accept_addr",  16'(rom_addr),    16'd1);
      applyStimulus(1'b0, 1'b1);
      checkIssue("stall_next", demoProg[1]);

      $display("[TB] reset in the middle of an issue");
      doReset();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
      checkIssue("midrst_before", demoProg[3]);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid",  16'(issue_valid), 16'd0);
      checkOutput("midrst_addr",   16'(rom_addr),    16'd0);
      checkOutput("midrst_busy",   16'(busy),        16'd0);
      checkOutput("midrst_halted", 16'(halted),      16'd0);
      checkOutput("midrst_op",     16'(issue_op),    16'd0);
      checkOutput("midrst_imm",    16'(issue_imm),   16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1);
      checkOutput("midrst_idle_busy", 16'(busy), 16'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midrst_refetch_addr", 16'(rom_addr), 16'd0);
      checkOutput("midrst_refetch_busy", 16'(busy),     16'd1);
      applyStimulus(1'b0, 1'b1);
      checkIssue("midrst_reissue", demoProg[0]);

      $display("[TB] all-LDI program wraps the program counter");
      doReset();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      applyStimulus(1'b1, 1'b1);
      for (int f = 0; f < 18; f++) begin
         checkOutput("wrap_fetch_addr",  16'(rom_addr),    16'(f % 16));
         checkOutput("wrap_fetch_valid", 16'(issue_valid), 16'd0);
         applyStimulus(1'b0, 1'b1);
         checkOutput("wrap_issue_valid", 16'(issue_valid), 16'd1);
         checkOutput("wrap_no_halt",     16'(halted),      16'd0);
         applyStimulus(1'b0, 1'b1);
      end

      $display("[TB] opcode 10 at word 2");
      doReset();
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h30 | i);
      rom[0] = 8'h01;
      rom[1] = 8'h11;
      rom[2] = 8'h89;
`ifdef FETCH_JUMP_EN
      jumpTarget = 4'd9;
`else
      jumpTarget = 4'd3;
`endif
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("op10_fetch_addr", 16'(rom_addr), 16'd2);
      applyStimulus(1'b0, 1'b1);
      checkOutput("op10_next_addr",  16'(rom_addr),    16'(jumpTarget));
      checkOutput("op10_no_issue",   16'(issue_valid), 16'd0);
      checkOutput("op10_busy",       16'(busy),        16'd1);
      applyStimulus(1'b0, 1'b1);
      checkIssue("op10_after", rom[jumpTarget]);

      $display("[TB] randomized programs with random back-pressure");
      for (int r = 0; r < 20; r++) begin
         doReset();
         for (int i = 0; i < 16; i++) begin
            int sel;
            logic [1:0] op;
            sel = int'($urandom_range(0, 9));
            op  = (sel == 0) ? 2'b01 : (sel < 3) ? 2'b10 : (sel < 6) ? 2'b00 : 2'b11;
            rom[i] = {op, 6'($urandom_range(0, 63))};
         end
         buildExpected();
         applyStimulus(1'b1, 1'($urandom_range(0, 1)));
         budget = 0;
         while (expQ.size() > 0 && budget < 400) begin
            nextReady = 1'($urandom_range(0, 1));
            if (issue_valid === 1'b1) begin
               w = expQ[0];
               checkIssue("rand_issue", w);
               if (nextReady) void'(expQ.pop_front());
            end
            applyStimulus(1'b0, nextReady);
            budget = budget + 1;
         end
         checkOutput("rand_drain", 16'(expQ.size()), 16'd0);
         if (expHalt) begin
            budget = 0;
            while (halted !== 1'b1 && budget < 80) begin
               applyStimulus(1'b0, 1'($urandom_range(0, 1)));
               budget = budget + 1;
            end
            checkOutput("rand_halted",    16'(halted),      16'd1);
            checkOutput("rand_halt_addr", 16'(rom_addr),    16'(haltPc));
            checkOutput("rand_halt_val",  16'(issue_valid), 16'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter START_ADDR, default 4'd0, first program address fetched after start.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins fetching at START_ADDR from IDLE or HALT.
REQ-005 rom_addr  output  4  instruction memory address (program counter).
REQ-006 rom_data  input  8  instruction word; combinational response to rom_addr, same cycle.
REQ-007 issue_valid  output  1  decoded instruction available to execute unit.
REQ-008 issue_ready  input  1  execute unit accepts instruction when high with issue_valid.
REQ-009 issue_op  output  2  opcode, IR[7:6].
REQ-010 issue_rd  output  2  destination register, IR[5:4].
REQ-011 issue_rs  output  2  source register, IR[3:2].
REQ-012 issue_imm  output  4  immediate, IR[3:0].
REQ-013 halted  output  1  high while in HALT state.
REQ-014 busy  output  1  high in FETCH or ISSUE.

Function
REQ-015 States SHALL be IDLE, FETCH, ISSUE, HALT, encoded in a 2-bit state register.
REQ-016 Opcodes: 00 LDI, 01 HALT, 10 JMP (see REQ-033/034), 11 ADD.
REQ-017 IDLE: rom_addr held; start -> PC=START_ADDR, next state FETCH.
REQ-018 FETCH: rom_addr=PC; IR latches rom_data at end of the cycle; PC increments mod 16.
REQ-019 From FETCH: latched op 01 -> HALT; op 00/11 -> ISSUE; op 10 per Configuration.
REQ-020 ISSUE: issue_valid=1, issue_* fields driven from IR, stable until handshake.
REQ-021 Handshake issue_valid&issue_ready -> next state FETCH; no handshake -> stay ISSUE, fields unchanged.
REQ-022 Latency: start at edge N -> FETCH cycle N+1 -> issue_valid at N+2; back-to-back accepted instructions issue every 2 cycles.
REQ-023 HALT instruction SHALL never assert issue_valid; HALT holds PC at halting address + 1.
REQ-024 HALT: start -> PC=START_ADDR, FETCH; otherwise remain.
REQ-025 start outside IDLE/HALT SHALL be ignored.
REQ-026 PC wrap: address 15 followed by address 0, no flag raised.
REQ-027 issue_ready while issue_valid low SHALL have no effect.
REQ-028 issue_* outputs outside ISSUE SHALL hold last IR value (0 after reset).

Reset
REQ-029 rst high SHALL immediately force state IDLE, PC=0, IR=0, issue_valid=0, halted=0, busy=0.
REQ-030 rst mid-ISSUE SHALL drop issue_valid asynchronously; pending instruction discarded.
REQ-031 First start after rst release behaves as REQ-017.
REQ-032 rom_addr after reset SHALL be 0.

Configuration
REQ-033 Macro FETCH_JUMP_EN defined: op 10 in FETCH loads PC=IR[3:0], next state FETCH, not issued; jump to own address loops without issuing.
REQ-034 FETCH_JUMP_EN undefined: op 10 treated as NOP -- not issued, PC already incremented, next state FETCH.

Verification
REQ-035 Program 0x01,0x11,0x21,0x31,0xC4,0xC8,0xCC,0x40, issue_ready=1, start -> 7 issues op/rd/imm = 00/0/1,00/1/1,00/2/1,00/3/1,11/0/4,11/0/8,11/0/C; then halted=1, rom_addr=8.
REQ-036 Same program, issue_ready held low 5 cycles on first issue -> issue_valid and fields 00/0/1 stable 5 cycles, rom_addr stays 1.
REQ-037 All 16 words 0x00, issue_ready=1 -> addresses 0..15,0,1 fetched in order; wrap with no halt.
REQ-038 rst asserted during ISSUE of word 3 -> same-cycle issue_valid=0, rom_addr=0; start after release refetches address 0.
REQ-039 Word 2 = 0x89: FETCH_JUMP_EN defined -> next fetch address 9, no issue; undefined -> next fetch address 3, no issue.
REQ-040 In HALT, start pulse -> FETCH at START_ADDR next cycle, halted=0; start during ISSUE -> ignored.
